ppwm_ctrl: RTL and testbench

// - Sequencer/configurator for N_CH ex program executors.
// - Owns the per-channel program memories, the global counter and the PWM period timer.
// - Generates start pulses and executor resets.
// - Accepts program/config writes over a valid/ready port and serves instr_o combinationally from each channel's pc.

---
 rtl/ppwm_pkg.sv | 20 ++
 rtl/ppwm_ctrl_if.sv | 13 +
 rtl/ppwm_prog_mem.sv | 24 ++
 rtl/ppwm_ctrl.sv | 122 ++++++++++++
 tb/tb_ppwm_ctrl.sv | 304 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/ppwm_pkg.sv
// Shared types and config address constants for the ppwm controller.
package ppwm_pkg;

   typedef enum logic [1:0] {
      StStop  = 2'd0,
      StRun   = 2'd1,
      StDrain = 2'd2
   } ctrl_state_e;

   localparam logic CfgSpaceProg = 1'b0;
   localparam logic CfgSpaceCtrl = 1'b1;
   localparam int   CfgIdxPeriod = 0;
   localparam int   CfgIdxEnable = 1;

   // Channel-select field width; a single channel still gets one address bit.
   function automatic int ch_width(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/ppwm_ctrl_if.sv
// Config write port: valid/ready handshake carrying {space, ch, idx} and data.
interface ppwm_ctrl_if #(
   parameter int ADDR_W = 6,
   parameter int DATA_W = 10
) ();
   logic              valid;
   logic              ready;
   logic [ADDR_W-1:0] addr;
   logic [DATA_W-1:0] data;

   modport master (output valid, addr, data, input  ready);
   modport slave  (input  valid, addr, data, output ready);
endinterface

// File: rtl/ppwm_prog_mem.sv
// One channel's program store: register file, single write port, async read.
module ppwm_prog_mem #(
   parameter int PC_WIDTH    = 4,
   parameter int INSTR_WIDTH = 7
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   we,
   input  logic [PC_WIDTH-1:0]    waddr,
   input  logic [INSTR_WIDTH-1:0] wdata,
   input  logic [PC_WIDTH-1:0]    raddr,
   output logic [INSTR_WIDTH-1:0] rdata
);
   localparam int DEPTH = 2 ** PC_WIDTH;

   logic [DEPTH-1:0][INSTR_WIDTH-1:0] mem;

   always_ff @(posedge clk) begin
      if (!rst_n)  mem        <= '0;
      else if (we) mem[waddr] <= wdata;
   end

   assign rdata = mem[raddr];
endmodule

// File: rtl/ppwm_ctrl.sv
// Sequencer for N_CH program executors: program memories, period timer,
// start pulses, executor reset and global counter.
module ppwm_ctrl
   import ppwm_pkg::*;
#(
   parameter int N_CH                 = 2,
   parameter int COUNTER_WIDTH        = 10,
   parameter int GLOBAL_COUNTER_WIDTH = 20,
   parameter int INSTR_WIDTH          = 7,
   parameter int PC_WIDTH             = 4
) (
   input  logic                            clk,
   input  logic                            rst_n,
   input  logic                            run_i,
   ppwm_ctrl_if.slave                      cfg,
   input  logic [N_CH*PC_WIDTH-1:0]        pc_i,
   output logic [N_CH*INSTR_WIDTH-1:0]     instr_o,
   output logic [N_CH-1:0]                 start_o,
   output logic                            ex_rst_n_o,
   output logic [GLOBAL_COUNTER_WIDTH-1:0] global_counter_o,
   output logic                            running_o
);
   localparam int CH_W = ch_width(N_CH);

   localparam logic [1:0] ST_STOP  = StStop;
   localparam logic [1:0] ST_RUN   = StRun;
   localparam logic [1:0] ST_DRAIN = StDrain;

   logic [1:0]                      state, state_nxt;
   logic [COUNTER_WIDTH-1:0]        pcnt, period_q, period_sh;
   logic [GLOBAL_COUNTER_WIDTH-1:0] gcnt;
   logic [N_CH-1:0]                 en_q, en_sh;
   logic                            start_pend;

   logic                space;
   logic [CH_W-1:0]     ch;
   logic [PC_WIDTH-1:0] idx;
   logic                wr, wr_period, wr_enable, wrap;

   assign {space, ch, idx} = cfg.addr;

   // Program memory is frozen while executors may be fetching from it.
   assign cfg.ready = (state == ST_STOP) || (space == CfgSpaceCtrl);
   assign wr        = cfg.valid && cfg.ready;
   assign wr_period = wr && (space == CfgSpaceCtrl) && (idx == PC_WIDTH'(CfgIdxPeriod));
   assign wr_enable = wr && (space == CfgSpaceCtrl) && (idx == PC_WIDTH'(CfgIdxEnable));
   assign wrap      = (state != ST_STOP) && (pcnt == period_sh);

   always_comb begin
      state_nxt = state;
      case (state)
         ST_STOP:  if (run_i) state_nxt = ST_RUN;
         ST_RUN:   if (!run_i) state_nxt = ST_DRAIN;
         ST_DRAIN: begin
            if (run_i)     state_nxt = ST_RUN;
            else if (wrap) state_nxt = ST_STOP;
         end
         default:  state_nxt = ST_STOP;
      endcase
   end

   // Shadows load from the pre-write registers, so a same-cycle write lands one wrap later.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state      <= ST_STOP;
         pcnt       <= '0;
         gcnt       <= '0;
         period_q   <= '0;
         period_sh  <= '0;
         en_q       <= '0;
         en_sh      <= '0;
         start_pend <= 1'b0;
      end else begin
         state      <= state_nxt;
         start_pend <= 1'b0;
         if (wr_period) period_q <= cfg.data;
         if (wr_enable) en_q     <= cfg.data[N_CH-1:0];
         if (state == ST_STOP) begin
            pcnt <= '0;
            gcnt <= '0;
            if (run_i) begin
               period_sh  <= period_q;
               en_sh      <= en_q;
               start_pend <= 1'b1;
            end
         end else begin
            gcnt <= (state_nxt == ST_STOP) ? '0 : gcnt + GLOBAL_COUNTER_WIDTH'(1);
            if (wrap) begin
               pcnt       <= '0;
               period_sh  <= period_q;
               en_sh      <= en_q;
               start_pend <= (state_nxt == ST_RUN);
            end else begin
               pcnt <= pcnt + COUNTER_WIDTH'(1);
            end
         end
      end
   end

   assign start_o          = {N_CH{start_pend}} & en_sh;
   assign ex_rst_n_o       = (state != ST_STOP);
   assign running_o        = (state != ST_STOP);
   assign global_counter_o = gcnt;

   for (genvar i = 0; i < N_CH; i++) begin : g_ch
      logic we;
      assign we = wr && (space == CfgSpaceProg) && (ch == CH_W'(i));

      ppwm_prog_mem #(
         .PC_WIDTH    (PC_WIDTH),
         .INSTR_WIDTH (INSTR_WIDTH)
      ) u_mem (
         .clk   (clk),
         .rst_n (rst_n),
         .we    (we),
         .waddr (idx),
         .wdata (cfg.data[INSTR_WIDTH-1:0]),
         .raddr (pc_i[i*PC_WIDTH +: PC_WIDTH]),
         .rdata (instr_o[i*INSTR_WIDTH +: INSTR_WIDTH])
      );
   end
endmodule

// File: tb/tb_ppwm_ctrl.sv
// Scoreboard bench for ppwm_ctrl; global counter narrowed so its wrap is reachable.
module tb_ppwm_ctrl;
   localparam int GCW = 12;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        run_in = 1'b0;
   logic [7:0]  pc = '0;
   logic [13:0] instr;
   logic [1:0]  start;
   logic        xr;
   logic [GCW-1:0] gc;
   logic        running;

   int n_chk = 0;
   int n_fail = 0;

   typedef struct {
      logic [1:0]     st;
      logic [GCW-1:0] gc;
      logic           xr;
      logic           rn;
   } exp_t;
   exp_t        exp_q[$];
   logic [6:0]  mem_q[$];

   localparam logic [5:0] ADDR_PERIOD = 6'b100000;
   localparam logic [5:0] ADDR_EN     = 6'b100001;

   ppwm_ctrl_if #(.ADDR_W(6), .DATA_W(10)) cfg ();

   ppwm_ctrl #(
      .N_CH(2), .COUNTER_WIDTH(10), .GLOBAL_COUNTER_WIDTH(GCW),
      .INSTR_WIDTH(7), .PC_WIDTH(4)
   ) dut (
      .clk(clk), .rst_n(rst_n), .run_i(run_in), .cfg(cfg), .pc_i(pc),
      .instr_o(instr), .start_o(start), .ex_rst_n_o(xr),
      .global_counter_o(gc), .running_o(running)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      run_in = 1'b0;
      cfg.valid = 1'b0;
      tick();
      tick();
      rst_n = 1'b1;
   endtask

   task automatic cfg_write(input logic [5:0] a, input logic [9:0] d);
      int n = 0;
      cfg.valid = 1'b1;
      cfg.addr = a;
      cfg.data = d;
      #1;
      while (!cfg.ready && n < 20) begin
         tick();
         n++;
      end
      n_chk++;
      if (n >= 20) begin
         n_fail++;
         $display("FAIL cfg_write_timeout addr=%b ready=%b required=1", a, cfg.ready);
      end
      tick();
      cfg.valid = 1'b0;
   endtask

   task automatic test_reset();
      cfg.addr = 6'b000000;
      cfg.data = '0;
      do_reset();
      n_chk++;
      if ({start, gc, xr, running} !== '0) begin
         n_fail++;
         $display("FAIL reset_outputs start=%b gc=%0d xr=%b running=%b required all 0", start, gc, xr, running);
      end
      n_chk++;
      if (cfg.ready !== 1'b1) begin
         n_fail++;
         $display("FAIL reset_ready got=%b required=1", cfg.ready);
      end
      n_chk++;
      if (instr !== '0) begin
         n_fail++;
         $display("FAIL reset_mem instr=%h required=0", instr);
      end
   endtask

   task automatic test_prog_mem();
      logic [6:0] w, e;
      for (int i = 0; i < 16; i++) begin
         w = 7'(i * 37 + 11);
         cfg_write({1'b0, 1'b0, 4'(i)}, {3'b101, w});
         mem_q.push_back(w);
      end
      for (int i = 0; i < 16; i++) begin
         pc = {4'(i), 4'(i)};
         #1;
         e = mem_q.pop_front();
         n_chk++;
         if (instr[6:0] !== e) begin
            n_fail++;
            $display("FAIL prog_ch0_%0d got=%h required=%h", i, instr[6:0], e);
         end
         n_chk++;
         if (instr[13:7] !== 7'h0) begin
            n_fail++;
            $display("FAIL prog_ch1_%0d got=%h required=0", i, instr[13:7]);
         end
      end
   endtask

   task automatic test_run();
      exp_t e;
      do_reset();
      cfg_write(ADDR_PERIOD, 10'd4);
      cfg_write(ADDR_EN, 10'd3);
      run_in = 1'b1;
      for (int k = 1; k <= 15; k++) begin
         e.st = (k == 1 || k == 6 || k == 11) ? 2'b11 : 2'b00;
         e.gc = GCW'(k - 1);
         e.xr = 1'b1;
         e.rn = 1'b1;
         exp_q.push_back(e);
         tick();
         e = exp_q.pop_front();
         n_chk++;
         if ({start, gc, xr, running} !== {e.st, e.gc, e.xr, e.rn}) begin
            n_fail++;
            $display("FAIL run_c%0d start=%b gc=%0d xr=%b run=%b required start=%b gc=%0d xr=%b run=%b",
                     k, start, gc, xr, running, e.st, e.gc, e.xr, e.rn);
         end
      end
      run_in = 1'b0;
   endtask

   task automatic test_reconfig();
      exp_t e;
      do_reset();
      cfg_write(ADDR_PERIOD, 10'd4);
      cfg_write(ADDR_EN, 10'd3);
      run_in = 1'b1;
      for (int k = 1; k <= 18; k++) begin
         e.st = (k == 1 || k == 6 || k == 9 || k == 12 || k == 17) ? 2'b11 : 2'b00;
         e.gc = GCW'(k - 1);
         e.xr = 1'b1;
         e.rn = 1'b1;
         exp_q.push_back(e);
         tick();
         e = exp_q.pop_front();
         n_chk++;
         if ({start, gc} !== {e.st, e.gc}) begin
            n_fail++;
            $display("FAIL reconf_c%0d start=%b gc=%0d required start=%b gc=%0d", k, start, gc, e.st, e.gc);
         end
         if (k == 3 || k == 9) cfg.valid = 1'b0;
         if (k == 2) begin
            cfg.valid = 1'b1;
            cfg.addr = 6'b000011;
            cfg.data = 10'h15;
            #1;
            n_chk++;
            if (cfg.ready !== 1'b0) begin
               n_fail++;
               $display("FAIL prog_write_stall ready=%b required=0", cfg.ready);
            end
            cfg.addr = ADDR_PERIOD;
            cfg.data = 10'd2;
            #1;
            n_chk++;
            if (cfg.ready !== 1'b1) begin
               n_fail++;
               $display("FAIL ctrl_write_ready ready=%b required=1", cfg.ready);
            end
         end
         // Write lands on the same edge as a wrap.
         if (k == 8) begin
            cfg.valid = 1'b1;
            cfg.addr = ADDR_PERIOD;
            cfg.data = 10'd4;
         end
      end
      run_in = 1'b0;
   endtask

   task automatic test_drain();
      exp_t e;
      do_reset();
      cfg_write(ADDR_PERIOD, 10'd4);
      cfg_write(ADDR_EN, 10'd3);
      run_in = 1'b1;
      for (int k = 1; k <= 8; k++) begin
         if (k <= 5) begin
            e.st = (k == 1) ? 2'b11 : 2'b00;
            e.gc = GCW'(k - 1);
            e.xr = 1'b1;
            e.rn = 1'b1;
         end else begin
            e.st = 2'b00;
            e.gc = '0;
            e.xr = 1'b0;
            e.rn = 1'b0;
         end
         exp_q.push_back(e);
         tick();
         e = exp_q.pop_front();
         n_chk++;
         if ({start, gc, xr, running} !== {e.st, e.gc, e.xr, e.rn}) begin
            n_fail++;
            $display("FAIL drain_c%0d start=%b gc=%0d xr=%b run=%b required start=%b gc=%0d xr=%b run=%b",
                     k, start, gc, xr, running, e.st, e.gc, e.xr, e.rn);
         end
         if (k == 3) run_in = 1'b0;
      end
   endtask

   task automatic test_period0();
      exp_t e;
      do_reset();
      cfg_write({1'b0, 1'b1, 4'd5}, 10'h2A);
      cfg_write(ADDR_PERIOD, 10'd0);
      cfg_write(ADDR_EN, 10'd1);
      pc = {4'd5, 4'd0};
      #1;
      n_chk++;
      if (instr[13:7] !== 7'h2A) begin
         n_fail++;
         $display("FAIL ch1_word got=%h required=2a", instr[13:7]);
      end
      run_in = 1'b1;
      for (int k = 1; k <= 6; k++) begin
         e.st = 2'b01;
         e.gc = GCW'(k - 1);
         e.xr = 1'b1;
         e.rn = 1'b1;
         exp_q.push_back(e);
         tick();
         e = exp_q.pop_front();
         n_chk++;
         if ({start, gc, xr, running} !== {e.st, e.gc, e.xr, e.rn}) begin
            n_fail++;
            $display("FAIL p0_c%0d start=%b gc=%0d xr=%b run=%b required start=%b gc=%0d", k, start, gc, xr, running, e.st, e.gc);
         end
      end
      rst_n = 1'b0;
      run_in = 1'b0;
      tick();
      n_chk++;
      if ({start, gc, xr, running, instr[13:7]} !== '0) begin
         n_fail++;
         $display("FAIL midrun_reset start=%b gc=%0d xr=%b run=%b ch1=%h required all 0", start, gc, xr, running, instr[13:7]);
      end
      rst_n = 1'b1;
   endtask

   task automatic test_gc_wrap();
      exp_t e;
      do_reset();
      cfg_write(ADDR_PERIOD, 10'd4);
      run_in = 1'b1;
      for (int k = 1; k <= (1 << GCW) + 3; k++) begin
         if (k == 1 || k >= (1 << GCW)) begin
            e.st = 2'b00;
            e.gc = GCW'(k - 1);
            e.xr = 1'b1;
            e.rn = 1'b1;
            exp_q.push_back(e);
         end
         tick();
         if (k == 1 || k >= (1 << GCW)) begin
            e = exp_q.pop_front();
            n_chk++;
            if (gc !== e.gc) begin
               n_fail++;
               $display("FAIL gc_wrap_c%0d got=%0d required=%0d", k, gc, e.gc);
            end
         end
      end
      run_in = 1'b0;
   endtask

   initial begin
      cfg.valid = 1'b0;
      cfg.addr = '0;
      cfg.data = '0;
      test_reset();
      test_prog_mem();
      test_run();
      test_reconfig();
      test_drain();
      test_period0();
      test_gc_wrap();
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
